cpu_microsequencer: RTL

//   Producer side of the cpu mir interface: holds a writable control store, walks

---
 rtl/cpu_microsequencer_pkg.sv | 31 +++
 rtl/cpu_microsequencer_store.sv | 26 ++
 rtl/cpu_microsequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_microsequencer_pkg.sv
// cpu_microsequencer_pkg: shared mir field layout, control-word sizing and sequencer states.
package cpu_microsequencer_pkg;

  localparam int unsigned MIR_W = 28;

  // mir field positions
  localparam int unsigned ALU_LSB      = 20;
  localparam int unsigned ALU_MSB      = 25;
  localparam int unsigned MEM_WR_LSB   = 19;
  localparam int unsigned MEM_WR_MSB   = 19;
  localparam int unsigned MEM_RD_LSB   = 18;
  localparam int unsigned MEM_RD_MSB   = 18;
  localparam int unsigned MEM_ADDR_LSB = 14;
  localparam int unsigned MEM_ADDR_MSB = 17;
  localparam int unsigned C_EN_LSB     = 4;
  localparam int unsigned C_EN_MSB     = 13;
  localparam int unsigned B_SEL_LSB    = 0;
  localparam int unsigned B_SEL_MSB    = 3;

  // Control word is {halt, hold[1:0], next[addr_w-1:0], mir[27:0]}
  function automatic int unsigned cw_width(input int unsigned addr_w);
    return MIR_W + addr_w + 3;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StHold
  } seq_state_e;

endpackage

// File: rtl/cpu_microsequencer_store.sv
// cpu_microsequencer_store: control-store array, synchronous write, asynchronous read.
module cpu_microsequencer_store #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CW_W   = 36
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [CW_W-1:0]   i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [CW_W-1:0]   o_rdata
);

  logic [CW_W-1:0] r_mem [2**ADDR_W];

  // Write port; contents are deliberately not reset
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read returns pre-write contents in the cycle a write is pending
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_microsequencer.sv
// cpu_microsequencer: walks microprograms held in a writable control store and drives the
// 28-bit mir word, holding each word for its dwell time.
// Define MICROSEQ_STEP_EN to add the i_step port (dwell/retire only on step edges).
module cpu_microsequencer
  import cpu_microsequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_cs_we,
  input  logic [ADDR_W-1:0]           i_cs_addr,
  input  logic [cw_width(ADDR_W)-1:0] i_cs_wdata,
  input  logic                        i_start,
  input  logic [ADDR_W-1:0]           i_start_addr,
`ifdef MICROSEQ_STEP_EN
  input  logic                        i_step,
`endif
  output logic [MIR_W-1:0]            o_mir,
  output logic                        o_mir_valid,
  output logic [ADDR_W-1:0]           o_upc,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int unsigned CW_W  = cw_width(ADDR_W);
  localparam int unsigned CNT_W = $clog2(READ_LAT + 4);
  localparam logic [CNT_W-1:0] RD_EXTRA = CNT_W'(READ_LAT - 1);

  seq_state_e        r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [MIR_W-1:0]  r_mir, w_mir_d;
  logic [ADDR_W-1:0] r_upc, w_upc_d;
  logic [ADDR_W-1:0] r_next, w_next_d;
  logic              r_valid, w_valid_d;
  logic              r_done, w_done_d;
  logic              r_halt, w_halt_d;

  logic              w_adv;
  logic              w_load;
  logic              w_cs_we;
  logic [ADDR_W-1:0] w_raddr;
  logic [CW_W-1:0]   w_rd_word;
  logic [MIR_W-1:0]  w_rd_mir;
  logic [ADDR_W-1:0] w_rd_next;
  logic [1:0]        w_rd_hold;
  logic              w_rd_halt;
  logic [CNT_W-1:0]  w_rd_dwell;

`ifdef MICROSEQ_STEP_EN
  assign w_adv = i_step;
`else
  assign w_adv = 1'b1;
`endif

  assign w_cs_we = i_cs_we && (r_state == StIdle);
  // Single read port: start address when idle, otherwise the current word's successor
  assign w_raddr = (r_state == StIdle) ? i_start_addr : r_next;

  cpu_microsequencer_store #(
    .ADDR_W (ADDR_W),
    .CW_W   (CW_W)
  ) u_store (
    .i_clock (i_clock),
    .i_we    (w_cs_we),
    .i_waddr (i_cs_addr),
    .i_wdata (i_cs_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rd_word)
  );

  assign w_rd_mir  = w_rd_word[MIR_W-1:0];
  assign w_rd_next = w_rd_word[MIR_W+ADDR_W-1:MIR_W];
  assign w_rd_hold = w_rd_word[CW_W-2 -: 2];
  assign w_rd_halt = w_rd_word[CW_W-1];
  // Extra edges beyond the first; a read (even with write also set) adds READ_LAT-1
  assign w_rd_dwell = CNT_W'(w_rd_hold) + (w_rd_mir[MEM_RD_LSB] ? RD_EXTRA : '0);

  // Next-state: FSM transitions, dwell countdown, word load and halt retirement
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_mir_d   = r_mir;
    w_upc_d   = r_upc;
    w_next_d  = r_next;
    w_valid_d = r_valid;
    w_halt_d  = r_halt;
    w_done_d  = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_load = 1'b1;
        end
      end
      StIssue, StHold: begin
        if (w_adv) begin
          if (r_cnt == '0) begin
            if (r_halt) begin
              w_state_d = StIdle;
              w_mir_d   = '0;
              w_valid_d = 1'b0;
              w_done_d  = 1'b1;
            end else begin
              w_load = 1'b1;
            end
          end else begin
            w_cnt_d   = r_cnt - CNT_W'(1);
            w_state_d = StHold;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_load) begin
      w_state_d = StIssue;
      w_mir_d   = w_rd_mir;
      w_upc_d   = w_raddr;
      w_next_d  = w_rd_next;
      w_halt_d  = w_rd_halt;
      w_cnt_d   = w_rd_dwell;
      w_valid_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_mir   <= '0;
      r_upc   <= '0;
      r_next  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_mir   <= w_mir_d;
      r_upc   <= w_upc_d;
      r_next  <= w_next_d;
      r_valid <= w_valid_d;
      r_done  <= w_done_d;
      r_halt  <= w_halt_d;
    end
  end

  assign o_mir       = r_mir;
  assign o_mir_valid = r_valid;
  assign o_upc       = r_upc;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;

endmodule
